fpmul_normrnd: RTL and testbench
================================

Name: fpmul_normrnd

Overview:
- Post-processing stage of the floating-point multiplier; sits directly downstream of the exponent adder and the mantissa multiplier.
- Consumes the unnormalised mantissa product, the combined biased exponent (expa+expb-bias, with carry and borrow retained) and the result sign.
- Produces a packed IEEE-754 result through a 2-stage valid/ready pipeline. Stages: normalise, then round-to-nearest-even with overflow/underflow resolution.

Parameters:
- EW, 8, exponent field width.
- MW, 23, stored mantissa fraction width; the significand including the hidden bit is MW+1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_vld  in  1  input operand valid.
- in_rdy  out  1  stage can accept; a transfer occurs when in_vld && in_rdy.
- in_sign  in  1  result sign (signa ^ signb).
- in_zero  in  1  either operand is zero.
- in_exp  in  EW+2  two's-complement value of expa+expb-bias; the MSB carries the borrow.
- in_prod  in  2*MW+2  unsigned significand product, in [1.0, 4.0) scaled by 2^(2MW).
- out_vld  out  1  result valid.
- out_rdy  in  1  downstream ready.
- out_res  out  EW+MW+1  packed {sign, exp, frac}.
- out_ovf  out  1  overflow occurred; result forced to ±inf.
- out_udf  out  1  underflow occurred; result flushed to ±0.
- out_inx  out  1  result inexact.

Behaviour:
- Reset values: out_vld=0, out_res=0, all flags=0, and both stage valid bits clear. in_rdy=1 immediately after reset.
- Handshake:
  - rdy2 = !s2_vld || out_rdy; in_rdy = !s1_vld || rdy2 (combinational, no bubbles).
  - A stage holds its contents while its downstream is not ready.
  - out_res and the flags are stable while out_vld && !out_rdy.
- Latency: 2 cycles from the accepting edge to out_vld. Throughput: 1 result per cycle with out_rdy held high.
- Stage 1 (normalise):
  - If in_prod[2MW+1]=1: sig = in_prod[2MW+1:MW+1], guard = in_prod[MW], sticky = |in_prod[MW-1:0], exp = in_exp+1.
  - Else: sig = in_prod[2MW:MW], guard = in_prod[MW-1], sticky = |in_prod[MW-2:0], exp = in_exp.
  - Exponent arithmetic is EW+2 bits signed and must not wrap.
- Stage 2 (round, RNE):
  - Round up when guard && (sticky || sig[0]).
  - A carry out of the MW+1-bit significand sets the fraction to 0 and increments exp.
  - inexact = guard || sticky.
- Stage 2 resolution, priority in this order:
  1. in_zero: {sign, 0, 0}, no flags set, regardless of exp.
  2. exp >= 2^EW-1: {sign, all-ones, 0}, ovf=1, inx=1.
  3. exp <= 0: {sign, 0, 0}, udf=1, inx=1. No subnormals are produced.
  4. Otherwise: {sign, exp[EW-1:0], sig[MW-1:0] after rounding}, inx per rounding.
- The overflow test uses the post-round exponent, so rounding can push a result into overflow.
- Simultaneous input accept and output drain in the same cycle is legal. No data is lost or duplicated.
- Reset asserted mid-operation discards all in-flight data and clears valids asynchronously.
- in_prod values outside [1.0, 4.0) are not permitted; behaviour for them is not required.

Decomposition:
- Shared package fpmul_pkg holds:
  - EW/MW defaults, EXP_MAX = 2^EW-1.
  - The packed-result field offsets.
  - The stage-1 to stage-2 struct {vld, sign, zero, exp[EW+1:0], sig[MW:0], guard, sticky}.
- One natural sub-module: fpmul_rne_round, the combinational RNE increment with carry-out, instantiated in stage 2.

Test Plan:
- 1.0x1.0: in_prod=0x400000000000, in_exp=127, sign 0 -> after 2 cycles out_res=0x3F800000, all flags 0.
- 1.5x1.5: in_prod=0x900000000000, in_exp=127 -> out_res=0x40100000, inx=0.
- Rounding carry: in_prod=0x7FFFFFC00000, in_exp=127 -> out_res=0x40000000, inx=1, ovf=0.
- Overflow: in_prod=0x800000000000, in_exp=254, sign 1 -> out_res=0xFF800000, ovf=1, inx=1.
- Underflow and zero:
  - in_prod=0x400000000000, in_exp=-5 (0x3FB) -> out_res=0x00000000, udf=1.
  - in_zero=1, in_exp=300 -> out_res=0, no flags set.
- Backpressure and reset:
  - Stream 4 operands with out_rdy low for 3 cycles. in_rdy must drop after 2 are held. Outputs must emerge in order, unchanged while stalled, with none lost.
  - Assert rst_n low mid-stream: out_vld falls immediately and the pipeline is empty after release.

Source files
------------

// File: rtl/fpmul_pkg.sv
// Shared definitions for the floating-point multiplier post-processing stage:
// default field widths, packed-result field offsets and the stage-1 to
// stage-2 pipeline register layout.
package fpmul_pkg;

  localparam int FP_EW = 8;
  localparam int FP_MW = 23;

  // Largest biased exponent value; reaching it means infinity.
  localparam int EXP_MAX = (1 << FP_EW) - 1;

  // Packed result layout {sign, exp, frac}.
  localparam int RES_FRAC_LSB = 0;
  localparam int RES_EXP_LSB  = FP_MW;
  localparam int RES_SIGN_BIT = FP_EW + FP_MW;

  // Normalised operand handed from the normalise stage to the round stage.
  typedef struct packed {
    logic               vld;
    logic               sign;
    logic               zero;
    logic [FP_EW+1:0]   exp;
    logic [FP_MW:0]     sig;
    logic               guard;
    logic               sticky;
  } s1_t;

endpackage

// File: rtl/fpmul_rne_round.sv
// Combinational round-to-nearest-even increment of a normalised significand.
// The hidden bit is always 1, so a carry out of the fraction is a carry out
// of the whole significand and leaves the fraction at zero.
module fpmul_rne_round #(
  parameter int MW = 23
) (
  input  logic [MW:0]   sig,
  input  logic          guard,
  input  logic          sticky,
  output logic [MW-1:0] frac,
  output logic          carry
);

  logic          round_up;
  logic [MW:0]   frac_sum;

  assign round_up = guard & (sticky | sig[0]);
  assign frac_sum = {1'b0, sig[MW-1:0]} + {{MW{1'b0}}, round_up};
  assign frac     = frac_sum[MW-1:0];
  assign carry    = sig[MW] & frac_sum[MW];

endmodule

// File: rtl/fpmul_normrnd.sv
// Floating-point multiplier back end: normalises the raw significand
// product, rounds to nearest even and resolves overflow/underflow through a
// two-stage valid/ready pipeline.
module fpmul_normrnd
  import fpmul_pkg::*;
#(
  parameter int EW = FP_EW,
  parameter int MW = FP_MW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic              in_sign,
  input  logic              in_zero,
  input  logic [EW+1:0]     in_exp,
  input  logic [2*MW+1:0]   in_prod,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [EW+MW:0]    out_res,
  output logic              out_ovf,
  output logic              out_udf,
  output logic              out_inx
);

  localparam logic [EW+1:0] EXP_ONE   = {{(EW+1){1'b0}}, 1'b1};
  localparam logic [EW:0]   EXP_LIMIT = {1'b0, {EW{1'b1}}};

  s1_t            s1;
  s1_t            s1_n;
  logic           s2_vld;
  logic           rdy2;
  logic [MW-1:0]  frac_rnd;
  logic           rnd_carry;
  logic [EW+1:0]  exp_post;
  logic [EW+MW:0] res_n;
  logic           ovf_n;
  logic           udf_n;
  logic           inx_n;

  // A stage advances when it is empty or its downstream takes its contents.
  assign rdy2    = !s2_vld || out_rdy;
  assign in_rdy  = !s1.vld || rdy2;
  assign out_vld = s2_vld;

  // Stage 1: shift a [2.0, 4.0) product down one place and split off guard/sticky.
  always_comb begin
    // NOTE: every field gets a default first so no path can leave a latch behind.
    s1_n      = '0;
    s1_n.vld  = in_vld;
    s1_n.sign = in_sign;
    s1_n.zero = in_zero;
    if (in_prod[2*MW+1]) begin
      s1_n.sig    = in_prod[2*MW+1:MW+1];
      s1_n.guard  = in_prod[MW];
      s1_n.sticky = |in_prod[MW-1:0];
      s1_n.exp    = in_exp + EXP_ONE;
    end else begin
      s1_n.sig    = in_prod[2*MW:MW];
      s1_n.guard  = in_prod[MW-1];
      s1_n.sticky = |in_prod[MW-2:0];
      s1_n.exp    = in_exp;
    end
  end

  // Stage-1 register holds while stage 2 is blocked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
    end else if (in_rdy) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      s1 <= s1_n;
    end
  end

  fpmul_rne_round #(.MW(MW)) u_round (
    .sig    (s1.sig),
    .guard  (s1.guard),
    .sticky (s1.sticky),
    .frac   (frac_rnd),
    .carry  (rnd_carry)
  );

  assign exp_post = s1.exp + {{(EW+1){1'b0}}, rnd_carry};

  // Stage 2: pick zero, infinity, flush-to-zero or the rounded normal result.
  always_comb begin
    res_n               = '0;
    res_n[RES_SIGN_BIT] = s1.sign;
    ovf_n               = 1'b0;
    udf_n               = 1'b0;
    inx_n               = s1.guard | s1.sticky;
    if (s1.zero) begin
      inx_n = 1'b0;
    end else if (!exp_post[EW+1] && (exp_post[EW:0] >= EXP_LIMIT)) begin
      res_n[RES_EXP_LSB +: EW] = '1;
      ovf_n                    = 1'b1;
      inx_n                    = 1'b1;
    end else if (exp_post[EW+1] || (exp_post == '0)) begin
      udf_n = 1'b1;
      inx_n = 1'b1;
    end else begin
      res_n[RES_EXP_LSB +: EW]  = exp_post[EW-1:0];
      res_n[RES_FRAC_LSB +: MW] = frac_rnd;
    end
  end

  // Output register; result and flags only change when a new result is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld  <= 1'b0;
      out_res <= '0;
      out_ovf <= 1'b0;
      out_udf <= 1'b0;
      out_inx <= 1'b0;
    end else if (rdy2) begin
      s2_vld <= s1.vld;
      if (s1.vld) begin
        out_res <= res_n;
        out_ovf <= ovf_n;
        out_udf <= udf_n;
        out_inx <= inx_n;
      end
    end
  end

endmodule

// File: tb/tb_fpmul_normrnd.sv
// Directed-vector bench for fpmul_normrnd: single-operand results with
// hand-computed expectations, a backpressure stream and mid-stream reset.
module tb_fpmul_normrnd;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_vld;
  logic        in_rdy;
  logic        in_sign;
  logic        in_zero;
  logic [9:0]  in_exp;
  logic [47:0] in_prod;
  logic        out_vld;
  logic        out_rdy;
  logic [31:0] out_res;
  logic        out_ovf;
  logic        out_udf;
  logic        out_inx;

  fpmul_normrnd dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (in_vld),
    .in_rdy  (in_rdy),
    .in_sign (in_sign),
    .in_zero (in_zero),
    .in_exp  (in_exp),
    .in_prod (in_prod),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .out_res (out_res),
    .out_ovf (out_ovf),
    .out_udf (out_udf),
    .out_inx (out_inx)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        sign;
    logic        zero;
    logic [9:0]  exp;
    logic [47:0] prod;
    logic [31:0] res;
    logic [2:0]  flg;   // {ovf, udf, inx}
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add(input string tag, input logic sign, input logic zero, input logic [9:0] exp,
                     input logic [47:0] prod, input logic [31:0] res, input logic [2:0] flg);
    vec_t v;
    v.tag = tag; v.sign = sign; v.zero = zero; v.exp = exp;
    v.prod = prod; v.res = res; v.flg = flg;
    vq.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    in_sign = v.sign;
    in_zero = v.zero;
    in_exp  = v.exp;
    in_prod = v.prod;
  endtask

  // One operand through an idle pipeline; checks latency, result and flags.
  task automatic run_vec(input vec_t v);
    int lat;
    @(negedge clk);
    drive(v);
    in_vld  = 1'b1;
    out_rdy = 1'b1;
    @(posedge clk);
    #1 in_vld = 1'b0;
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (out_vld) break;
    end
    check({v.tag, "_lat"}, lat, 2);
    check({v.tag, "_res"}, out_res, v.res);
    check({v.tag, "_flg"}, {out_ovf, out_udf, out_inx}, v.flg);
  endtask

  initial begin
    int   sent;
    int   got;
    int   spurious;
    int   bp_idx[4];
    vec_t expq[$];
    vec_t h;

    rst_n   = 1'b0;
    in_vld  = 1'b0;
    out_rdy = 1'b0;
    in_sign = 1'b0;
    in_zero = 1'b0;
    in_exp  = '0;
    in_prod = '0;

    //   tag          sign  zero  exp        prod               res           {ovf,udf,inx}
    add("one",        1'b0, 1'b0, 10'd127,  48'h400000000000, 32'h3F800000, 3'b000);
    add("one_neg",    1'b1, 1'b0, 10'd127,  48'h400000000000, 32'hBF800000, 3'b000);
    add("sq15",       1'b0, 1'b0, 10'd127,  48'h900000000000, 32'h40100000, 3'b000);
    add("rnd_carry",  1'b0, 1'b0, 10'd127,  48'h7FFFFFC00000, 32'h40000000, 3'b001);
    add("tie_even",   1'b0, 1'b0, 10'd127,  48'h400000400000, 32'h3F800000, 3'b001);
    add("tie_odd",    1'b0, 1'b0, 10'd127,  48'h400000C00000, 32'h3F800002, 3'b001);
    add("sticky_hi",  1'b0, 1'b0, 10'd127,  48'hC00000000001, 32'h40400000, 3'b001);
    add("max_norm",   1'b0, 1'b0, 10'd254,  48'h7FFFFF800000, 32'h7F7FFFFF, 3'b000);
    add("ovf",        1'b1, 1'b0, 10'd254,  48'h800000000000, 32'hFF800000, 3'b101);
    add("ovf_rnd",    1'b0, 1'b0, 10'd254,  48'h7FFFFFC00000, 32'h7F800000, 3'b101);
    add("udf",        1'b0, 1'b0, 10'h3FB,  48'h400000000000, 32'h00000000, 3'b011);
    add("udf_exp0",   1'b1, 1'b0, 10'd0,    48'h400000000000, 32'h80000000, 3'b011);
    add("min_norm",   1'b0, 1'b0, 10'd0,    48'h800000000000, 32'h00800000, 3'b000);
    add("zero",       1'b0, 1'b1, 10'd300,  48'h400000000000, 32'h00000000, 3'b000);

    // Reset state.
    #12;
    check("rst_out_vld", out_vld, 1'b0);
    check("rst_out_res", out_res, 32'h0);
    check("rst_flags", {out_ovf, out_udf, out_inx}, 3'b000);
    check("rst_in_rdy", in_rdy, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_in_rdy_rel", in_rdy, 1'b1);

    foreach (vq[i]) run_vec(vq[i]);

    // Backpressure: four operands, out_rdy low for the first three valid-output cycles.
    bp_idx = '{2, 3, 8, 13};
    sent = 0;
    got  = 0;
    for (int t = 0; t < 16; t++) begin
      @(negedge clk);
      out_rdy = (t >= 5);
      in_vld  = (sent < 4);
      if (sent < 4) drive(vq[bp_idx[sent]]);
      #1;
      if (t == 1) check("bp_rdy_second", in_rdy, 1'b1);
      if (t == 2 || t == 4) check("bp_rdy_drop", in_rdy, 1'b0);
      if (out_vld) begin
        if (expq.size() == 0) begin
          check("bp_extra_out", 1'b1, 1'b0);
        end else if (out_rdy) begin
          h = expq.pop_front();
          check({"bp_", h.tag, "_res"}, out_res, h.res);
          check({"bp_", h.tag, "_flg"}, {out_ovf, out_udf, out_inx}, h.flg);
          got++;
        end else begin
          h = expq[0];
          check({"bp_hold_", h.tag}, {out_ovf, out_udf, out_inx, out_res}, {h.flg, h.res});
        end
      end
      if (in_vld && in_rdy) begin
        expq.push_back(vq[bp_idx[sent]]);
        sent++;
      end
    end
    in_vld = 1'b0;
    check("bp_sent", sent, 4);
    check("bp_got", got, 4);

    // Mid-stream reset: fill both stages, then reset between clock edges.
    @(negedge clk);
    out_rdy = 1'b0;
    drive(vq[2]);
    in_vld = 1'b1;
    @(negedge clk);
    drive(vq[3]);
    @(negedge clk);
    in_vld = 1'b0;
    check("mid_pre_vld", out_vld, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_vld", out_vld, 1'b0);
    check("mid_rst_res", out_res, 32'h0);
    check("mid_rst_rdy", in_rdy, 1'b1);
    @(negedge clk);
    rst_n   = 1'b1;
    out_rdy = 1'b1;
    spurious = 0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (out_vld) spurious++;
    end
    check("mid_empty", spurious, 0);
    run_vec(vq[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
